// File: rtl/lsu_load_fmt.sv
// ---------------------------------------------------------------------------
// lsu_load_fmt
//   Load-result formatter for the LSU. Each issued load pushes a tag
//   {size, unsigned, off, rd} into an in-order FIFO. Each returning 32-bit
//   lane-aligned read word pops the oldest tag. The word is then sliced
//   (byte/half/word), sign- or zero-extended, and registered onto the
//   writeback port.
//
//   Handshake rule (all channels): a transfer happens on a rising clk edge
//   where valid and ready are both 1. A valid source holds its payload
//   stable until that edge. o_wb_* is registered and stays stable while
//   o_wb_valid=1 and i_wb_ready=0.
//
//   Optional build macro: LSU_LOAD_FMT_MISALIGN_CHK_EN
//     If defined, half loads with off[0]=1 and word loads with off!=0 set
//     o_wb_misalign=1 and force o_wb_dat to 0. The tag is still popped.
//     If undefined, o_wb_misalign is always 0. Half loads use only off[1],
//     and word loads ignore off.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   i_req_valid / o_req_ready   load issue; payload i_req_size, i_req_unsigned,
//                               i_req_off, i_req_rd
//   i_rsp_valid / o_rsp_ready   read response; payload i_rsp_dat, i_rsp_err
//   o_wb_valid / i_wb_ready     writeback; payload o_wb_dat, o_wb_rd,
//                               o_wb_err, o_wb_misalign
//   o_idle                      no tags in flight and no pending writeback
// ---------------------------------------------------------------------------
module lsu_load_fmt #(
  parameter int TAG_DEPTH_LOG2 = 1,
  parameter int RD_AW          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_size,
  input  logic             i_req_unsigned,
  input  logic [1:0]       i_req_off,
  input  logic [RD_AW-1:0] i_req_rd,
  input  logic             i_rsp_valid,
  output logic             o_rsp_ready,
  input  logic [31:0]      i_rsp_dat,
  input  logic             i_rsp_err,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [31:0]      o_wb_dat,
  output logic [RD_AW-1:0] o_wb_rd,
  output logic             o_wb_err,
  output logic             o_wb_misalign,
  output logic             o_idle
);

  localparam int DEPTH = 1 << TAG_DEPTH_LOG2;
  localparam int PW    = TAG_DEPTH_LOG2;
  localparam int CW    = TAG_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [1:0]       size;
    logic             uns;
    logic [1:0]       off;
    logic [RD_AW-1:0] rd;
  } tag_t;

  // Tag FIFO state
  tag_t          mem_q [DEPTH];
  tag_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Writeback registers
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_dat_q, wb_dat_d;
  logic [RD_AW-1:0] wb_rd_q, wb_rd_d;
  logic             wb_err_q, wb_err_d;
  logic             wb_mis_q, wb_mis_d;

  logic  fifo_full, fifo_empty;
  logic  push, pop;
  tag_t  tag_in, head;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] fmt_dat;
  logic        mis;

  // The full flag comes only from registered occupancy. A pop in the same
  // cycle does not make room for a push.
  assign fifo_full   = (cnt_q == DEPTH_C);
  assign fifo_empty  = (cnt_q == '0);
  assign o_req_ready = !fifo_full;
  // Because the empty flag is registered, a tag pushed this cycle cannot
  // service a response until the next cycle.
  assign o_rsp_ready = !fifo_empty && (!wb_valid_q || i_wb_ready);
  assign push        = i_req_valid && o_req_ready;
  assign pop         = i_rsp_valid && o_rsp_ready;

  assign tag_in = '{size: i_req_size, uns: i_req_unsigned, off: i_req_off, rd: i_req_rd};
  assign head   = mem_q[rd_ptr_q];

  // Lane extraction for the tag at the head of the FIFO
  always_comb begin
    byte_v  = 8'(i_rsp_dat >> {head.off, 3'b000});
    half_v  = head.off[1] ? i_rsp_dat[31:16] : i_rsp_dat[15:0];
    fmt_dat = i_rsp_dat;
    case (head.size)
      2'd0:    fmt_dat = {{24{~head.uns & byte_v[7]}}, byte_v};
      2'd1:    fmt_dat = {{16{~head.uns & half_v[15]}}, half_v};
      default: fmt_dat = i_rsp_dat;  // word, and reserved size 3
    endcase
  end

`ifdef LSU_LOAD_FMT_MISALIGN_CHK_EN
  assign mis = ((head.size == 2'd1) && head.off[0]) ||
               ((head.size == 2'd2) && (head.off != 2'd0));
`else
  assign mis = 1'b0;
`endif

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = tag_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // wraps modulo depth
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Writeback next state. A new result loads on pop; otherwise the current
  // result holds until it is accepted.
  always_comb begin
    wb_valid_d = wb_valid_q && !i_wb_ready;
    wb_dat_d   = wb_dat_q;
    wb_rd_d    = wb_rd_q;
    wb_err_d   = wb_err_q;
    wb_mis_d   = wb_mis_q;
    if (pop) begin
      wb_valid_d = 1'b1;
      wb_dat_d   = (i_rsp_err || mis) ? 32'd0 : fmt_dat;
      wb_rd_d    = head.rd;
      wb_err_d   = i_rsp_err;
      wb_mis_d   = mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_dat_q   <= '0;
      wb_rd_q    <= '0;
      wb_err_q   <= 1'b0;
      wb_mis_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_dat_q   <= wb_dat_d;
      wb_rd_q    <= wb_rd_d;
      wb_err_q   <= wb_err_d;
      wb_mis_q   <= wb_mis_d;
    end
  end

  assign o_wb_valid    = wb_valid_q;
  assign o_wb_dat      = wb_dat_q;
  assign o_wb_rd       = wb_rd_q;
  assign o_wb_err      = wb_err_q;
  assign o_wb_misalign = wb_mis_q;
  assign o_idle        = fifo_empty && !wb_valid_q;

endmodule

// File: tb/tb_lsu_load_fmt.sv
// ---------------------------------------------------------------------------
// tb_lsu_load_fmt
//   Directed bench for lsu_load_fmt with default parameters (depth 2,
//   RD_AW 5). Inputs change 1 time unit after a rising edge. Outputs are
//   checked at the same point or 1 unit later, so no check lands on a clock
//   edge. The expected values are worked out by hand from the load format
//   rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_load_fmt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_req_size = '0;
  logic        i_req_unsigned = 1'b0;
  logic [1:0]  i_req_off = '0;
  logic [4:0]  i_req_rd = '0;
  logic        i_rsp_valid = 1'b0;
  logic        o_rsp_ready;
  logic [31:0] i_rsp_dat = '0;
  logic        i_rsp_err = 1'b0;
  logic        o_wb_valid;
  logic        i_wb_ready = 1'b1;
  logic [31:0] o_wb_dat;
  logic [4:0]  o_wb_rd;
  logic        o_wb_err;
  logic        o_wb_misalign;
  logic        o_idle;

  int checks = 0;
  int errors = 0;

  lsu_load_fmt #(.TAG_DEPTH_LOG2(1), .RD_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_off(i_req_off), .i_req_rd(i_req_rd),
    .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready),
    .i_rsp_dat(i_rsp_dat), .i_rsp_err(i_rsp_err),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_dat(o_wb_dat), .o_wb_rd(o_wb_rd), .o_wb_err(o_wb_err),
    .o_wb_misalign(o_wb_misalign), .o_idle(o_idle)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks. Each one starts and ends 1 unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic [1:0] size, input logic uns,
                          input logic [1:0] off, input logic [4:0] rd);
    i_req_valid = 1'b1; i_req_size = size; i_req_unsigned = uns;
    i_req_off = off; i_req_rd = rd;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] dat, input logic err);
    i_rsp_valid = 1'b1; i_rsp_dat = dat; i_rsp_err = err;
    @(posedge clk); #1;
    i_rsp_valid = 1'b0; i_rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b exp 0", o_wb_valid); end
    checks++; if (o_wb_dat !== 32'd0) begin errors++; $display("FAIL reset_wb_dat got %h exp 00000000", o_wb_dat); end
    checks++; if (o_wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d exp 0", o_wb_rd); end
    checks++; if ({o_wb_err, o_wb_misalign} !== 2'b00) begin errors++; $display("FAIL reset_err_mis got %b exp 00", {o_wb_err, o_wb_misalign}); end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    next_cycle();
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", o_req_ready); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b exp 1", o_idle); end
    checks++; if (o_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %0b exp 0", o_rsp_ready); end
  endtask

  // Byte, signed, off=3: the top byte 0x80 is sign-extended.
  task automatic test_byte_signed();
    // A response alongside the first push finds the FIFO still empty.
    i_req_valid = 1'b1; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_off = 2'd3; i_req_rd = 5'd5;
    i_rsp_valid = 1'b1; i_rsp_dat = 32'h80FF_FFFF;
    #1;
    checks++; if (o_rsp_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_tag got %0b exp 0", o_rsp_ready); end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL early_wb_valid got %0b exp 0", o_wb_valid); end
    checks++; if (o_rsp_ready !== 1'b1) begin errors++; $display("FAIL next_cycle_tag got %0b exp 1", o_rsp_ready); end
    @(posedge clk); #1;
    i_rsp_valid = 1'b0;
    checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL byte_s_valid got %0b exp 1", o_wb_valid); end
    checks++; if (o_wb_dat !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_s_dat got %h exp ffffff80", o_wb_dat); end
    checks++; if (o_wb_rd !== 5'd5) begin errors++; $display("FAIL byte_s_rd got %0d exp 5", o_wb_rd); end
    checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL busy_idle got %0b exp 0", o_idle); end
    next_cycle();
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL wb_clear got %0b exp 0", o_wb_valid); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL idle_after got %0b exp 1", o_idle); end
  endtask

  task automatic test_formats();
    // Half unsigned, off=2
    send_req(2'd1, 1'b1, 2'd2, 5'd6); send_rsp(32'hBEEF_1234, 1'b0);
    checks++; if (o_wb_dat !== 32'h0000_BEEF) begin errors++; $display("FAIL half_u_dat got %h exp 0000beef", o_wb_dat); end
    next_cycle();
    // Byte unsigned, off=1
    send_req(2'd0, 1'b1, 2'd1, 5'd7); send_rsp(32'h1234_5678, 1'b0);
    checks++; if (o_wb_dat !== 32'h0000_0056) begin errors++; $display("FAIL byte_u_dat got %h exp 00000056", o_wb_dat); end
    next_cycle();
    // Half signed, off=0
    send_req(2'd1, 1'b0, 2'd0, 5'd8); send_rsp(32'h1234_8001, 1'b0);
    checks++; if (o_wb_dat !== 32'hFFFF_8001) begin errors++; $display("FAIL half_s_dat got %h exp ffff8001", o_wb_dat); end
    next_cycle();
    // Byte signed, off=0, with a positive byte
    send_req(2'd0, 1'b0, 2'd0, 5'd9); send_rsp(32'hFFFF_FF7F, 1'b0);
    checks++; if (o_wb_dat !== 32'h0000_007F) begin errors++; $display("FAIL byte_pos_dat got %h exp 0000007f", o_wb_dat); end
    next_cycle();
    // Word, off=0
    send_req(2'd2, 1'b0, 2'd0, 5'd10); send_rsp(32'hDEAD_BEEF, 1'b0);
    checks++; if (o_wb_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_dat got %h exp deadbeef", o_wb_dat); end
    next_cycle();
    // Reserved size is treated as a word
    send_req(2'd3, 1'b0, 2'd0, 5'd11); send_rsp(32'h0123_4567, 1'b0);
    checks++; if (o_wb_dat !== 32'h0123_4567) begin errors++; $display("FAIL rsvd_dat got %h exp 01234567", o_wb_dat); end
    next_cycle();
    // Bus error zeroes the data
    send_req(2'd2, 1'b0, 2'd0, 5'd12); send_rsp(32'hFFFF_FFFF, 1'b1);
    checks++; if (o_wb_err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b exp 1", o_wb_err); end
    checks++; if (o_wb_dat !== 32'd0) begin errors++; $display("FAIL err_dat got %h exp 00000000", o_wb_dat); end
    checks++; if (o_wb_rd !== 5'd12) begin errors++; $display("FAIL err_rd got %0d exp 12", o_wb_rd); end
    next_cycle();
  endtask

  task automatic test_misalign();
    send_req(2'd2, 1'b0, 2'd1, 5'd13); send_rsp(32'hCAFE_BABE, 1'b0);
`ifdef LSU_LOAD_FMT_MISALIGN_CHK_EN
    checks++; if (o_wb_misalign !== 1'b1) begin errors++; $display("FAIL word_mis_flag got %0b exp 1", o_wb_misalign); end
    checks++; if (o_wb_dat !== 32'd0) begin errors++; $display("FAIL word_mis_dat got %h exp 00000000", o_wb_dat); end
`else
    checks++; if (o_wb_misalign !== 1'b0) begin errors++; $display("FAIL word_mis_flag got %0b exp 0", o_wb_misalign); end
    checks++; if (o_wb_dat !== 32'hCAFE_BABE) begin errors++; $display("FAIL word_mis_dat got %h exp cafebabe", o_wb_dat); end
`endif
    next_cycle();
    send_req(2'd1, 1'b0, 2'd1, 5'd14); send_rsp(32'h1234_ABCD, 1'b0);
`ifdef LSU_LOAD_FMT_MISALIGN_CHK_EN
    checks++; if (o_wb_dat !== 32'd0) begin errors++; $display("FAIL half_mis_dat got %h exp 00000000", o_wb_dat); end
    checks++; if (o_wb_misalign !== 1'b1) begin errors++; $display("FAIL half_mis_flag got %0b exp 1", o_wb_misalign); end
`else
    checks++; if (o_wb_dat !== 32'hFFFF_ABCD) begin errors++; $display("FAIL half_mis_dat got %h exp ffffabcd", o_wb_dat); end
    checks++; if (o_wb_misalign !== 1'b0) begin errors++; $display("FAIL half_mis_flag got %0b exp 0", o_wb_misalign); end
`endif
    next_cycle();
    // The misaligned loads still popped their tags.
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL mis_idle got %0b exp 1", o_idle); end
  endtask

  // Depth-2 full behaviour, then back-to-back responses.
  task automatic test_fifo_full();
    send_req(2'd2, 1'b0, 2'd0, 5'd1);
    send_req(2'd2, 1'b0, 2'd0, 5'd2);
    i_req_valid = 1'b1; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_off = 2'd0; i_req_rd = 5'd3;
    #1;
    checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", o_req_ready); end
    @(posedge clk); #1;
    checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %0b exp 0", o_req_ready); end
    // Pop the first tag. The request held at the same edge is not taken.
    i_rsp_valid = 1'b1; i_rsp_dat = 32'h0000_0001;
    @(posedge clk); #1;
    i_rsp_valid = 1'b0;
    checks++; if (o_wb_rd !== 5'd1) begin errors++; $display("FAIL full_first_rd got %0d exp 1", o_wb_rd); end
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL full_release got %0b exp 1", o_req_ready); end
    @(posedge clk); #1;   // the third request is pushed here
    i_req_valid = 1'b0;
    // Two responses on consecutive cycles give results on consecutive cycles.
    i_rsp_valid = 1'b1; i_rsp_dat = 32'h0000_0002;
    @(posedge clk); #1;
    checks++; if (o_wb_rd !== 5'd2 || o_wb_dat !== 32'h2) begin errors++; $display("FAIL b2b_first got rd %0d dat %h exp rd 2 dat 00000002", o_wb_rd, o_wb_dat); end
    i_rsp_dat = 32'h0000_0003;
    @(posedge clk); #1;
    i_rsp_valid = 1'b0;
    checks++; if (o_wb_valid !== 1'b1 || o_wb_rd !== 5'd3 || o_wb_dat !== 32'h3) begin errors++; $display("FAIL b2b_second got v %0b rd %0d dat %h exp v 1 rd 3 dat 00000003", o_wb_valid, o_wb_rd, o_wb_dat); end
    next_cycle();
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL full_idle got %0b exp 1", o_idle); end
  endtask

  // Writeback stall with a second response waiting.
  task automatic test_backpressure();
    send_req(2'd0, 1'b1, 2'd0, 5'd7);
    send_req(2'd1, 1'b1, 2'd0, 5'd8);
    i_wb_ready = 1'b0;
    send_rsp(32'h0000_00AA, 1'b0);
    i_rsp_valid = 1'b1; i_rsp_dat = 32'h0000_BBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_rsp_ready c%0d got %0b exp 0", i, o_rsp_ready); end
      checks++; if (o_wb_valid !== 1'b1 || o_wb_dat !== 32'hAA || o_wb_rd !== 5'd7) begin errors++; $display("FAIL bp_hold c%0d got v %0b dat %h rd %0d exp v 1 dat 000000aa rd 7", i, o_wb_valid, o_wb_dat, o_wb_rd); end
      @(posedge clk); #0;
    end
    #1;
    i_wb_ready = 1'b1;
    #1;
    checks++; if (o_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", o_rsp_ready); end
    @(posedge clk); #1;
    i_rsp_valid = 1'b0;
    checks++; if (o_wb_valid !== 1'b1 || o_wb_dat !== 32'hBBBB || o_wb_rd !== 5'd8) begin errors++; $display("FAIL bp_second got v %0b dat %h rd %0d exp v 1 dat 0000bbbb rd 8", o_wb_valid, o_wb_dat, o_wb_rd); end
    next_cycle();
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL bp_clear got %0b exp 0", o_wb_valid); end
  endtask

  // Reset with two tags in flight and a result pending.
  task automatic test_reset_mid();
    send_req(2'd2, 1'b0, 2'd0, 5'd20);
    send_req(2'd2, 1'b0, 2'd0, 5'd21);
    i_wb_ready = 1'b0;
    send_rsp(32'h5555_AAAA, 1'b0);
    send_req(2'd2, 1'b0, 2'd0, 5'd22);
    checks++; if (o_wb_valid !== 1'b1 || o_req_ready !== 1'b0) begin errors++; $display("FAIL pre_rst got v %0b rdy %0b exp v 1 rdy 0", o_wb_valid, o_req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if ({o_wb_valid, o_wb_err, o_wb_misalign} !== 3'b000 || o_wb_dat !== 32'd0 || o_wb_rd !== 5'd0) begin errors++; $display("FAIL mid_rst_out got v %0b dat %h rd %0d exp all 0", o_wb_valid, o_wb_dat, o_wb_rd); end
    checks++; if (o_idle !== 1'b1 || o_req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got idle %0b rdy %0b exp 1 1", o_idle, o_req_ready); end
    next_cycle();
    rst_n = 1'b1;
    i_wb_ready = 1'b1;
    i_rsp_valid = 1'b1; i_rsp_dat = 32'h1111_1111;
    #1;
    checks++; if (o_rsp_ready !== 1'b0) begin errors++; $display("FAIL post_rst_stall got %0b exp 0", o_rsp_ready); end
    @(posedge clk); #1;
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL post_rst_wb got %0b exp 0", o_wb_valid); end
    i_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_formats();
    test_misalign();
    test_fifo_full();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
